// File: rtl/arb_mux2_rr_pkg.sv
// Shared types for the two-source round-robin arbiter and its datapath mux.
package arb_mux2_rr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : arb_mux2_rr_pkg

// File: rtl/arb_mux2_rr_mux2_w.sv
// Parameterised W-bit combinational 2:1 mux (sel = 0 -> a, sel = 1 -> b).
module mux2_w
  import arb_mux2_rr_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y_c
);

  always_comb begin
    y_c = a;
    if (sel == SEL_B) y_c = b;
  end

endmodule : mux2_w

// File: rtl/arb_mux2_rr.sv
// Two-requester round-robin arbiter with burst limit, owning a W-bit 2:1 mux
// whose output is registered with a valid strobe.
module arb_mux2_rr
  import arb_mux2_rr_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [W-1:0] dat_a,
  input  logic [W-1:0] dat_b,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         sel,
  output logic [W-1:0] sal,
  output logic         sal_vld
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  state_t          state;
  state_t          state_nxt;
  logic            last_served;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [W-1:0]    mux_y;
  logic            req_own;
  logic            req_oth;
  logic            beat;
  logic            cnt_full;
  logic            release_grant;

  mux2_w #(.W(W)) u_mux (
    .sel (sel),
    .a   (dat_a),
    .b   (dat_b),
    .y_c (mux_y)
  );

  // Beat, burst-limit and release decode for the current owner.
  always_comb begin
    req_own = 1'b0;
    req_oth = 1'b0;
    case (state)
      GNT_A: begin
        req_own = req_a;
        req_oth = req_b;
      end
      GNT_B: begin
        req_own = req_b;
        req_oth = req_a;
      end
      default: ;
    endcase
    beat          = (state != IDLE) && req_own;
    cnt_nxt       = cnt + CW'(1);
    cnt_full      = beat && (cnt_nxt == CW'(MAX_BURST));
    release_grant = (state != IDLE) && (!req_own || (cnt_full && req_oth));
  end

  // Next-state: ties from IDLE go to whoever was not served last; a release
  // hands straight over to a waiting peer with no idle bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || last_served == SEL_B)) state_nxt = GNT_A;
        else if (req_b)                                state_nxt = GNT_B;
      end
      GNT_A: if (release_grant) state_nxt = req_b ? GNT_B : IDLE;
      GNT_B: if (release_grant) state_nxt = req_a ? GNT_A : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= SEL_B;
      cnt         <= '0;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      sel         <= SEL_A;
      sal         <= '0;
      sal_vld     <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt_a   <= (state_nxt == GNT_A);
      gnt_b   <= (state_nxt == GNT_B);
      sel     <= (state_nxt == GNT_B) ? SEL_B : SEL_A;
      sal_vld <= beat;
      if (beat) sal <= mux_y;

      // A full burst with no competitor just restarts the count.
      if (release_grant) begin
        last_served <= (state == GNT_B) ? SEL_B : SEL_A;
        cnt         <= '0;
      end else if (beat) begin
        cnt <= cnt_full ? '0 : cnt_nxt;
      end
    end
  end

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) !(gnt_a && gnt_b));
  a_sel_gnt_b  : assert property (@(posedge clk) disable iff (!rst_n) sel == gnt_b);
  a_cnt_bound  : assert property (@(posedge clk) disable iff (!rst_n) cnt <= CW'(MAX_BURST));

endmodule : arb_mux2_rr

// File: tb/tb_arb_mux2_rr.sv
// Scoreboard bench for arb_mux2_rr: one instance with MAX_BURST=4, one with MAX_BURST=1.
module tb_arb_mux2_rr;

  logic       clk;
  logic       rst_n;
  logic       req_a0, req_b0, req_a1, req_b1;
  logic [7:0] dat_a0, dat_b0, dat_a1, dat_b1;
  logic       gnt_a0, gnt_b0, sel0, sal_vld0;
  logic       gnt_a1, gnt_b1, sel1, sal_vld1;
  logic [7:0] sal0, sal1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ga;
    logic       gb;
    logic       vld;
    logic       chk_sal;
    logic [7:0] sal;
  } exp_t;

  exp_t sb_q[$];

  arb_mux2_rr #(.W(8), .MAX_BURST(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a0), .req_b(req_b0),
    .dat_a(dat_a0), .dat_b(dat_b0), .gnt_a(gnt_a0), .gnt_b(gnt_b0),
    .sel(sel0), .sal(sal0), .sal_vld(sal_vld0)
  );

  arb_mux2_rr #(.W(8), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a1), .req_b(req_b1),
    .dat_a(dat_a1), .dat_b(dat_b1), .gnt_a(gnt_a1), .gnt_b(gnt_b1),
    .sel(sel1), .sal(sal1), .sal_vld(sal_vld1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outcome, compare after the edge.
  task automatic step(input bit u, input logic ra, input logic rb,
                      input logic [7:0] da, input logic [7:0] db,
                      input logic ega, input logic egb, input logic evld,
                      input logic echk, input logic [7:0] esal, input string tag);
    exp_t e;
    exp_t o;
    logic og_a, og_b, o_sel, o_vld;
    logic [7:0] o_sal;
    @(negedge clk);
    if (!u) begin
      req_a0 = ra; req_b0 = rb; dat_a0 = da; dat_b0 = db;
    end else begin
      req_a1 = ra; req_b1 = rb; dat_a1 = da; dat_b1 = db;
    end
    e = '{ega, egb, evld, echk, esal};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o     = sb_q.pop_front();
    og_a  = u ? gnt_a1   : gnt_a0;
    og_b  = u ? gnt_b1   : gnt_b0;
    o_sel = u ? sel1     : sel0;
    o_vld = u ? sal_vld1 : sal_vld0;
    o_sal = u ? sal1     : sal0;
    check({tag, ".gnt_a"},   32'(og_a),  32'(o.ga));
    check({tag, ".gnt_b"},   32'(og_b),  32'(o.gb));
    check({tag, ".sel"},     32'(o_sel), 32'(o.gb));
    check({tag, ".sal_vld"}, 32'(o_vld), 32'(o.vld));
    if (o.chk_sal) check({tag, ".sal"}, 32'(o_sal), 32'(o.sal));
  endtask

  initial begin
    logic       own_b, last;
    logic [7:0] da, db;

    rst_n  = 1'b0;
    req_a0 = 1'b0; req_b0 = 1'b0; dat_a0 = '0; dat_b0 = '0;
    req_a1 = 1'b0; req_b1 = 1'b0; dat_a1 = '0; dat_b1 = '0;

    // Reset values
    @(posedge clk);
    #1;
    check("rst.gnt_a",   32'(gnt_a0),   32'(0));
    check("rst.gnt_b",   32'(gnt_b0),   32'(0));
    check("rst.sel",     32'(sel0),     32'(0));
    check("rst.sal",     32'(sal0),     32'(0));
    check("rst.sal_vld", 32'(sal_vld0), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester: six beats, grant held across the burst limit
    step(0, 1, 0, 8'h0F, 8'h00, 1, 0, 0, 1, 8'h00, "single.arb");
    for (int i = 0; i < 6; i++)
      step(0, 1, 0, 8'(8'h10 + i), 8'h00, 1, 0, 1, 1, 8'(8'h10 + i), "single.beat");
    step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h15, "single.drop");

    // Fair bursts: A x4, B x4, A x4, B x4 with no bubble
    step(0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h15, "fair.arb");
    for (int n = 0; n < 16; n++) begin
      own_b = ((n / 4) % 2) == 1;
      last  = (n % 4) == 3;
      da    = 8'(8'h20 + n);
      db    = 8'(8'h60 + n);
      step(0, 1, 1, da, db, own_b ? last : !last, own_b ? !last : last,
           1, 1, own_b ? db : da, "fair");
    end

    // Early release after two A beats; B then gets a full four-beat burst
    step(0, 1, 1, 8'h31, 8'h71, 1, 0, 1, 1, 8'h31, "early.a1");
    step(0, 1, 1, 8'h32, 8'h72, 1, 0, 1, 1, 8'h32, "early.a2");
    step(0, 0, 1, 8'h33, 8'h73, 0, 1, 0, 1, 8'h32, "early.drop");
    for (int n = 0; n < 4; n++)
      step(0, 1, 1, 8'(8'h40 + n), 8'(8'h80 + n), n == 3, n != 3, 1, 1,
           8'(8'h80 + n), "early.b");

    // Tie from idle after B was served: A must win
    step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h83, "tie.idle");
    step(0, 0, 1, 8'h00, 8'h90, 0, 1, 0, 1, 8'h83, "tie.b_arb");
    step(0, 0, 1, 8'h00, 8'h91, 0, 1, 1, 1, 8'h91, "tie.b_beat");
    step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h91, "tie.b_drop");
    step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h91, "tie.idle2");
    step(0, 1, 1, 8'hA0, 8'hB0, 1, 0, 0, 1, 8'h91, "tie.both");

    // Reach GNT_B with a live beat, then reset asynchronously mid-cycle
    step(0, 0, 1, 8'h00, 8'hC0, 0, 1, 0, 1, 8'h91, "mid.to_b");
    step(0, 0, 1, 8'h00, 8'hC1, 0, 1, 1, 1, 8'hC1, "mid.b_beat");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.gnt_a",   32'(gnt_a0),   32'(0));
    check("arst.gnt_b",   32'(gnt_b0),   32'(0));
    check("arst.sel",     32'(sel0),     32'(0));
    check("arst.sal_vld", 32'(sal_vld0), 32'(0));
    check("arst.sal",     32'(sal0),     32'(0));
    req_a0 = 1'b1;
    req_b0 = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(0, 1, 1, 8'hD0, 8'hE0, 1, 0, 0, 1, 8'h00, "post_rst.arb");
    step(0, 1, 1, 8'hD1, 8'hE1, 1, 0, 1, 1, 8'hD1, "post_rst.a");

    // MAX_BURST = 1: grant and data alternate every cycle
    step(1, 1, 1, 8'hAA, 8'h55, 1, 0, 0, 1, 8'h00, "mb1.arb");
    for (int n = 0; n < 6; n++)
      step(1, 1, 1, 8'hAA, 8'h55, (n % 2) == 1, (n % 2) == 0, 1, 1,
           ((n % 2) == 0) ? 8'hAA : 8'h55, "mb1");

    check("sb.empty", 32'(sb_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_arb_mux2_rr

// File: doc/arb_mux2_rr.md
Name: arb_mux2_rr

Overview:
- Two-requester round-robin arbiter that owns a W-bit 2:1 datapath mux.
- Decides which source (A or B) drives the shared output each cycle.
- Issues grants and drives the mux select.
- Registers the selected data with a valid strobe for the downstream consumer.

Parameters:
- W, 8, data width of each source and of the output.
- MAX_BURST, 4, maximum consecutive beats one source may transfer while the other is requesting. Legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_a  input  1  source A requests the output; data on dat_a valid when high.
- req_b  input  1  source B requests the output.
- dat_a  input  W  source A data.
- dat_b  input  W  source B data.
- gnt_a  output  1  registered grant to A.
- gnt_b  output  1  registered grant to B.
- sel  output  1  mux select: 0 = A, 1 = B; registered, equals gnt_b.
- sal  output  W  registered mux output.
- sal_vld  output  1  sal holds a transferred beat.

Behaviour:
- Interface fixed: one clock clk; rst_n asynchronous, active-low. Assertion clears all state immediately, with no clock required. Deassertion takes effect at the next rising clk.
- Reset values:
  - State IDLE.
  - gnt_a = 0, gnt_b = 0, sel = 0, sal = 0, sal_vld = 0.
  - Internal last_served = B, so A wins the first tie.
  - Burst counter = 0.
- States: IDLE, GNT_A, GNT_B. gnt_a is high exactly in GNT_A; gnt_b and sel are high exactly in GNT_B.
- IDLE:
  - req_a & req_b -> grant the source that is not last_served.
  - Only one request -> grant that source.
  - No request -> stay in IDLE.
  - Grant is visible the cycle after the request is sampled; one-cycle arbitration latency.
- GNT_X, beat definition: a beat is a cycle with req_X = 1 while gnt_X = 1.
- GNT_X, on each beat:
  - sal <= dat_X, taken through the mux with the current sel.
  - sal_vld <= 1.
  - Burst counter increments.
- On a non-beat cycle: sal_vld <= 0 and sal holds its last value.
- Release condition, evaluated on the same edge:
  - req_X = 0, or
  - counter reaches MAX_BURST on this beat while the other source requests.
- On release:
  - If the other source requests, go directly to GNT_other with no idle bubble.
  - Otherwise go to IDLE.
  - Set last_served = X and clear the counter.
- Counter at MAX_BURST with the other source not requesting: counter clears and the grant is held; no forced release.
- MAX_BURST = 1 with both sources requesting continuously: grant alternates every cycle, A,B,A,B...
- Output latency: data sampled on a beat appears on sal/sal_vld one cycle later.
- Counter width: clog2(MAX_BURST+1); it never exceeds MAX_BURST.
- Requester contract: a requester may drop req at any cycle; dat_X is a don't-care when req_X = 0.
- Reset mid-burst: gnt, sel and sal_vld drop immediately and asynchronously; the in-flight beat is discarded; arbitration restarts from IDLE with A preferred.

Decomposition:
- Shared package holds:
  - The state enum (IDLE, GNT_A, GNT_B).
  - Select encodings SEL_A = 0, SEL_B = 1.
- One sub-module is natural: mux2_w, a parameterised W-bit combinational 2:1 mux (sel = 0 -> a, sel = 1 -> b). The arbiter instantiates it and registers its output.
- The FSM, counter and output register stay in the top module.

Test Plan:
- Reset:
  - Stimulus: assert rst_n = 0 mid-cycle while GNT_B with sal_vld = 1.
  - Response: gnt_b, sel and sal_vld go to 0 without a clock edge.
  - After release, with req_a = req_b = 1: gnt_a = 1 two edges later.
- Single requester:
  - Stimulus: req_a = 1 for 6 cycles with dat_a = 0x10..0x15, req_b = 0, MAX_BURST = 4.
  - Response: gnt_a held throughout with no forced release.
  - sal = 0x10..0x15 on consecutive cycles, each one cycle after its beat; sal_vld = 1 for 6 cycles.
- Fair burst:
  - Stimulus: both sources request continuously, MAX_BURST = 4.
  - Response: grant pattern A×4, B×4, A×4.
  - Switch cycles have no gap; sal_vld stays 1 continuously after the first beat.
  - sel toggles together with the grant.
- Early release:
  - Stimulus: in GNT_A, req_a drops after 2 beats while req_b = 1.
  - Response: gnt_b = 1 on the next edge; the counter restarts so B gets a full 4-beat burst.
- Tie from idle after B served:
  - Stimulus: B completes a burst, both go idle, then both request in the same cycle.
  - Response: A is granted first.
- MAX_BURST = 1:
  - Stimulus: both request with dat_a = 0xAA, dat_b = 0x55.
  - Response: sal alternates 0xAA, 0x55, 0xAA... every cycle with sal_vld = 1.
